// File: rtl/cp0_int_ctrl_if.sv
// CP0 interrupt-controller bus: MTC0 write port, Status view and the
// interrupt request/acknowledge handshake with the exception logic.
interface cp0_int_ctrl_if;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [31:0] cp0_status;
  logic        int_ack;
  logic        int_req;

  modport master (
    output mtc0_we, mtc0_addr, mtc0_wdata, cp0_status, int_ack,
    input  int_req
  );

  modport slave (
    input  mtc0_we, mtc0_addr, mtc0_wdata, cp0_status, int_ack,
    output int_req
  );
endinterface

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: Cause.IP/TI, Count/Compare timer, external line
// synchronisers and the request/acknowledge FSM towards the exception logic.
module cp0_int_ctrl #(
  parameter int COUNT_DIV   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic [5:0]  i_ext_int,
  cp0_int_ctrl_if.slave bus,
  output logic [7:0]  o_cause_ip,
  output logic        o_cause_ti,
  output logic [31:0] o_count,
  output logic [31:0] o_compare
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_EXL = 2'd2
  } state_t;

  localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic [1:0]  r_div;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic [1:0]  r_ip_soft;
  state_t      r_state;
  logic        r_wcnt;
  logic        r_int_req;

  state_t      w_next;
  logic        w_wcnt_next;
  logic [5:0]  w_ext;
  logic [7:0]  w_ip;
  logic        w_pending;
  logic        w_exl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_cause;
  logic        w_match;
  logic        w_unused;

  assign w_wr_count   = bus.mtc0_we && (bus.mtc0_addr == 5'd9);
  assign w_wr_compare = bus.mtc0_we && (bus.mtc0_addr == 5'd11);
  assign w_wr_cause   = bus.mtc0_we && (bus.mtc0_addr == 5'd13);
  assign w_match      = (r_count == r_compare) && (r_compare != 32'd0);

  assign w_ext     = r_sync[SYNC_STAGES-1];
  assign w_ip      = {w_ext[5] | r_ti, w_ext[4:0], r_ip_soft};
  assign w_exl     = bus.cp0_status[1];
  assign w_pending = bus.cp0_status[0] & ~w_exl & (|(bus.cp0_status[15:8] & w_ip));
  assign w_unused  = &{1'b0, bus.cp0_status[31:16], bus.cp0_status[7:2],
                       bus.mtc0_wdata[31:10], bus.mtc0_wdata[7:0]};

  // External line synchronisers and software-writable IP[1:0]
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sync    <= '0;
      r_ip_soft <= 2'b00;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_ext_int};
      if (w_wr_cause) begin
        r_ip_soft <= bus.mtc0_wdata[9:8];
      end
    end
  end

  // Count/Compare timer; MTC0 writes take priority over increment and match
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_div     <= 2'd0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= bus.mtc0_wdata;
        r_div   <= 2'd0;
      end else if (r_div == DIV_LAST) begin
        r_count <= r_count + 32'd1;
        r_div   <= 2'd0;
      end else begin
        r_div <= r_div + 2'd1;
      end
      if (w_wr_compare) begin
        r_compare <= bus.mtc0_wdata;
        r_ti      <= 1'b0;
      end else if (w_match) begin
        r_ti <= 1'b1;
      end
    end
  end

  // Request FSM state register; int_req is registered from the next state
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state   <= S_IDLE;
      r_wcnt    <= 1'b0;
      r_int_req <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wcnt    <= w_wcnt_next;
      r_int_req <= (w_next == S_REQ);
    end
  end

  // Next-state logic; WAIT_EXL gives up after two clocks if EXL never shows
  always_comb begin
    w_next      = r_state;
    w_wcnt_next = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          w_next = S_REQ;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_REQ: begin
        if (bus.int_ack) begin
          w_next      = S_WAIT_EXL;
          w_wcnt_next = 1'b0;
        end else if (!w_pending) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_REQ;
        end
      end
      S_WAIT_EXL: begin
        if (w_exl || r_wcnt) begin
          w_next = S_IDLE;
        end else begin
          w_next      = S_WAIT_EXL;
          w_wcnt_next = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign bus.int_req = r_int_req;
  assign o_cause_ip  = w_ip;
  assign o_cause_ti  = r_ti;
  assign o_count     = r_count;
  assign o_compare   = r_compare;

endmodule
